ncl_sync_bridge: RTL
====================

# ncl_sync_bridge

Clocked bridge between synchronous logic and a dual-rail NCL W-bit ripple adder. Upstream side: accepts binary operands via valid/ready and drives them as dual-rail DATA/NULL wavefronts into the adder's A/B/carry-in. Downstream side: collects the adder's dual-rail sum and carry-out, acknowledges via completion signal, and presents results on a valid/ready port. Serves as the synchronous environment/test harness for NCL adder chains.

## Interface
- W, 4, operand/sum width in bits (≥1)
- SYNC_STAGES, 2, flops per async-to-clk synchronizer (≥2)

- clk  in  1  clock
- init  in  1  synchronous active-high reset
- in_valid  in  1  operand offered
- in_ready  out  1  bridge accepts operand this cycle
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_cin  in  1  carry-in
- ncl_a  out  2W  dual-rail A; bit i on [2i+1:2i]
- ncl_b  out  2W  dual-rail B
- ncl_cin  out  2  dual-rail carry-in
- ncl_in_comp  in  1  adder input completion (high = DATA consumed, low = NULL consumed)
- ncl_sum  in  2W  dual-rail sum from adder
- ncl_cout  in  2  dual-rail carry-out
- ncl_out_comp  out  1  completion to adder (high = DATA captured, low = request DATA)
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_sum  out  W  binary sum
- out_cout  out  1  binary carry-out
- out_err  out  1  sticky: illegal rail code (2'b11) seen in a captured result

## Operation
- Dual-rail encoding per bit {rail1,rail0}: 2'b00 NULL, 2'b01 value 0, 2'b10 value 1, 2'b11 illegal.
- ncl_in_comp is asynchronous: SYNC_STAGES-flop synchronizer, reset value 1.
- Transmit FSM (drives ncl_a/ncl_b/ncl_cin from registers only):
  - TX_NULL: all rails 0; in_ready=0; → TX_IDLE when synced comp == 0.
  - TX_IDLE: in_ready=1; on in_valid&in_ready register encoded operands, → TX_DATA.
  - TX_DATA: rails hold DATA; → TX_NULL (rails cleared next cycle) when synced comp == 1.
- Receive side: combinational completeness on ncl_sum/ncl_cout: data_complete = every bit pair non-NULL; all_null = every rail 0. Each flag synchronized through SYNC_STAGES flops (reset 0).
- Receive FSM:
  - RX_WAIT_DATA: ncl_out_comp=0; when synced data_complete=1 and out_valid=0 (or being taken same cycle), capture ncl_sum/ncl_cout directly (stable until ack), decode rail1 → binary, set out_valid, set out_err if any pair == 2'b11, → RX_WAIT_NULL.
  - RX_WAIT_NULL: ncl_out_comp=1; when synced all_null=1 → RX_WAIT_DATA.
- out_valid clears on out_valid&out_ready; out_sum/out_cout hold while out_valid=1.
- out_err cleared only by init.

## Timing
- Reset (init high at clk edge): ncl_a/ncl_b/ncl_cin = 0 (NULL), ncl_out_comp=0, in_ready=0, out_valid=0, out_sum=0, out_cout=0, out_err=0; TX_NULL, RX_WAIT_DATA; synchronizers forced to reset values.
- init mid-operation: same as above next cycle; any wavefront in flight abandoned; in_ready rises no earlier than SYNC_STAGES+1 cycles after init falls, and only once ncl_in_comp is low.
- in_ready is registered from state; at most one operand per DATA/NULL cycle.
- DATA launch: rails change the cycle after acceptance.
- Receive capture latency: SYNC_STAGES+1 cycles after data_complete becomes stable; ncl_out_comp rises same cycle as out_valid.
- Back-pressure: if out_valid=1 and out_ready=0, result held, ncl_out_comp stays 0, adder stalls in DATA; upstream stalls through ncl_in_comp.
- Simultaneous out_ready take and new data_complete: capture allowed same cycle (take and reload).
- No combinational path from any ncl_* input to any output.

## Test plan
- Reset: init high 3 cycles with ncl_in_comp=1 → all rails 0, in_ready=0, out_valid=0; drop ncl_in_comp → in_ready=1 within SYNC_STAGES+1 cycles.
- Single add W=4, A=4'b0101, B=4'b0011, cin=0 through behavioral NCL adder → ncl_a=8'b01100110, out_sum=4'b1000, out_cout=0, out_err=0, then rails return to NULL and ncl_out_comp falls.
- Overflow A=4'hF, B=4'h1, cin=1 → out_sum=4'h1, out_cout=1.
- Back-pressure: out_ready=0 for 20 cycles across two issued operands → first result held, ncl_out_comp stays 0 after capture/NULL, second operand not accepted until first taken; results in order.
- Illegal code: force ncl_sum bit 2 pair to 2'b11 at DATA → out_err=1, stays 1 until init.
- Reset mid-DATA: assert init while TX_DATA → next cycle rails NULL, out_valid=0; subsequent A=3,B=4 yields out_sum=7.

Source files
------------

// File: rtl/ncl_sync_bridge.sv
// rtl/ncl_sync_bridge.sv - clocked valid/ready bridge to a dual-rail NCL ripple adder
//
// Drives binary operands into an NCL adder as DATA/NULL wavefronts and returns
// the dual-rail sum as a binary result on a valid/ready port.
//
// Ports:
//   clk, init                      clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_cin   operand handshake
//   ncl_a, ncl_b, ncl_cin          dual-rail operands to adder ({rail1,rail0} per bit)
//   ncl_in_comp                    adder input completion (asynchronous)
//   ncl_sum, ncl_cout              dual-rail result from adder (asynchronous)
//   ncl_out_comp                   completion back to adder (1 = DATA captured)
//   out_valid/out_ready/out_sum/out_cout   result handshake
//   out_err                        sticky illegal-code flag
module ncl_sync_bridge #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           init,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_cin,
    output logic [2*W-1:0] ncl_a,
    output logic [2*W-1:0] ncl_b,
    output logic [1:0]     ncl_cin,
    input  logic           ncl_in_comp,
    input  logic [2*W-1:0] ncl_sum,
    input  logic [1:0]     ncl_cout,
    output logic           ncl_out_comp,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_sum,
    output logic           out_cout,
    output logic           out_err
);

    typedef enum logic [1:0] {TX_NULL, TX_IDLE, TX_DATA} tx_state_t;
    typedef enum logic       {RX_WAIT_DATA, RX_WAIT_NULL} rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    logic      tx_load, tx_clear, rx_capture;

    // Synchronizers for the asynchronous completion indications.
    logic [SYNC_STAGES-1:0] comp_sync, dc_sync, null_sync;
    logic comp_s, dc_s, null_s;
    logic data_complete, all_null, illegal;
    logic [W-1:0]   sum_bin;
    logic [2*W-1:0] enc_a, enc_b;

    always_comb begin
        data_complete = (ncl_cout != 2'b00);
        illegal       = (ncl_cout == 2'b11);
        sum_bin       = '0;
        enc_a         = '0;
        enc_b         = '0;
        for (int i = 0; i < W; i++) begin
            if (ncl_sum[2*i +: 2] == 2'b00) data_complete = 1'b0;
            if (ncl_sum[2*i +: 2] == 2'b11) illegal = 1'b1;
            sum_bin[i]      = ncl_sum[2*i+1];
            enc_a[2*i +: 2] = in_a[i] ? 2'b10 : 2'b01;
            enc_b[2*i +: 2] = in_b[i] ? 2'b10 : 2'b01;
        end
    end

    assign all_null = ~|{ncl_sum, ncl_cout};

    always_ff @(posedge clk) begin
        if (init) begin
            comp_sync <= '1;
            dc_sync   <= '0;
            null_sync <= '0;
        end else begin
            comp_sync <= {comp_sync[SYNC_STAGES-2:0], ncl_in_comp};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], data_complete};
            null_sync <= {null_sync[SYNC_STAGES-2:0], all_null};
        end
    end

    assign comp_s = comp_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];
    assign null_s = null_sync[SYNC_STAGES-1];

    // Transmit side: rails come only from registers so the adder never sees glitches.
    always_ff @(posedge clk) begin
        if (init) begin
            tx_state <= TX_NULL;
            ncl_a    <= '0;
            ncl_b    <= '0;
            ncl_cin  <= 2'b00;
        end else begin
            tx_state <= tx_next;
            if (tx_load) begin
                ncl_a   <= enc_a;
                ncl_b   <= enc_b;
                ncl_cin <= in_cin ? 2'b10 : 2'b01;
            end else if (tx_clear) begin
                ncl_a   <= '0;
                ncl_b   <= '0;
                ncl_cin <= 2'b00;
            end
        end
    end

    always_comb begin
        tx_next  = tx_state;
        tx_load  = 1'b0;
        tx_clear = 1'b0;
        case (tx_state)
            TX_NULL: if (!comp_s) tx_next = TX_IDLE;
            TX_IDLE: if (in_valid) begin
                tx_load = 1'b1;
                tx_next = TX_DATA;
            end
            TX_DATA: if (comp_s) begin
                tx_clear = 1'b1;
                tx_next  = TX_NULL;
            end
            default: tx_next = TX_NULL;
        endcase
    end

    assign in_ready = (tx_state == TX_IDLE);

    // Receive side: the sum is sampled directly because the adder holds it
    // stable until ncl_out_comp acknowledges; only the completeness flags are
    // synchronized. A pending result blocks capture unless it is taken this cycle.
    always_ff @(posedge clk) begin
        if (init) begin
            rx_state  <= RX_WAIT_DATA;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (rx_capture) begin
                out_valid <= 1'b1;
                out_sum   <= sum_bin;
                out_cout  <= ncl_cout[1];
                if (illegal) out_err <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        rx_next    = rx_state;
        rx_capture = 1'b0;
        case (rx_state)
            RX_WAIT_DATA: if (dc_s && (!out_valid || out_ready)) begin
                rx_capture = 1'b1;
                rx_next    = RX_WAIT_NULL;
            end
            RX_WAIT_NULL: if (null_s) rx_next = RX_WAIT_DATA;
            default:      rx_next = RX_WAIT_DATA;
        endcase
    end

    assign ncl_out_comp = (rx_state == RX_WAIT_NULL);

endmodule
